// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: block/length widths, the initial hash value
// and the padder state encoding.
package sha256_pkg;

  localparam int BLOCK_W     = 512;
  localparam int LEN_W       = 64;
  localparam int BLOCK_BYTES = BLOCK_W / 8;
  localparam int LEN_BYTES   = LEN_W / 8;

  // Last byte position that still leaves room for the 64-bit length field.
  localparam int LAST_MARKER_POS = BLOCK_BYTES - LEN_BYTES - 1;

  localparam logic [255:0] H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_PAD  = 2'd1,
    S_OUT  = 2'd2
  } padder_state_e;

endpackage

// File: rtl/sha256_padder.sv
// Byte-stream to 512-bit block padder for SHA-256: appends the 0x80 marker,
// zero fill and the 64-bit big-endian bit length, emitting one block at a time.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int CNT_W = 61
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_first,
  output logic               blk_last
);

  padder_state_e      state_reg, state_next;
  logic [5:0]         ptr_reg, ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               pad_pending_reg, pad_pending_next;
  logic               marker_reg, marker_next;
  logic               final_reg, final_next;
  logic               len_pending_reg, len_pending_next;
  logic               first_pending_reg, first_pending_next;
  logic [BLOCK_W-1:0] blk_reg, blk_next;

  logic               accept;
  logic               place_len;
  logic [LEN_W-1:0]   bit_len;

  assign accept    = (state_reg == S_DATA) && in_valid;
  assign place_len = marker_reg || (ptr_reg <= 6'(LAST_MARKER_POS));
  assign bit_len   = LEN_W'({cnt_reg, 3'b000});

  // Per-byte datapath: load incoming byte at ptr, or apply marker/zero/length in S_PAD.
  for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
    localparam int HI = BLOCK_W - 1 - 8 * gi;
    logic [7:0] pad_byte;
    logic [7:0] pad_final;

    assign pad_byte = (marker_reg || (6'(gi) > ptr_reg)) ? 8'h00 :
                      (6'(gi) == ptr_reg)                ? 8'h80 :
                                                           blk_reg[HI -: 8];

    if (gi >= BLOCK_BYTES - LEN_BYTES) begin : g_len
      assign pad_final = place_len ? bit_len[HI -: 8] : pad_byte;
    end else begin : g_nolen
      assign pad_final = pad_byte;
    end

    assign blk_next[HI -: 8] = (accept && (ptr_reg == 6'(gi))) ? in_data   :
                               (state_reg == S_PAD)            ? pad_final :
                                                                 blk_reg[HI -: 8];
  end

  always_comb begin
    state_next         = state_reg;
    ptr_next           = ptr_reg;
    cnt_next           = cnt_reg;
    pad_pending_next   = pad_pending_reg;
    marker_next        = marker_reg;
    final_next         = final_reg;
    len_pending_next   = len_pending_reg;
    first_pending_next = first_pending_reg;

    unique case (state_reg)
      S_DATA: begin
        if (in_valid) begin
          ptr_next = ptr_reg + 6'd1;
          cnt_next = cnt_reg + CNT_W'(1);
          if (in_last) begin
            pad_pending_next = 1'b1;
          end
          // A full block goes out first; padding (if pending) follows in a fresh block.
          if (ptr_reg == 6'd63) begin
            state_next       = S_OUT;
            final_next       = 1'b0;
            len_pending_next = 1'b0;
          end else if (in_last) begin
            state_next = S_PAD;
          end
        end
      end

      S_PAD: begin
        marker_next      = 1'b1;
        final_next       = place_len;
        len_pending_next = !place_len;
        state_next       = S_OUT;
      end

      S_OUT: begin
        if (blk_ready) begin
          first_pending_next = final_reg;
          if (final_reg) begin
            state_next       = S_DATA;
            ptr_next         = 6'd0;
            cnt_next         = '0;
            pad_pending_next = 1'b0;
            marker_next      = 1'b0;
            final_next       = 1'b0;
          end else if (len_pending_reg) begin
            state_next       = S_PAD;
            len_pending_next = 1'b0;
          end else if (pad_pending_reg) begin
            state_next = S_PAD;
          end else begin
            state_next = S_DATA;
            ptr_next   = 6'd0;
          end
        end
      end

      default: begin
        state_next = S_DATA;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= S_DATA;
      ptr_reg           <= 6'd0;
      cnt_reg           <= '0;
      pad_pending_reg   <= 1'b0;
      marker_reg        <= 1'b0;
      final_reg         <= 1'b0;
      len_pending_reg   <= 1'b0;
      first_pending_reg <= 1'b1;
      blk_reg           <= '0;
    end else begin
      state_reg         <= state_next;
      ptr_reg           <= ptr_next;
      cnt_reg           <= cnt_next;
      pad_pending_reg   <= pad_pending_next;
      marker_reg        <= marker_next;
      final_reg         <= final_next;
      len_pending_reg   <= len_pending_next;
      first_pending_reg <= first_pending_next;
      blk_reg           <= blk_next;
    end
  end

  assign in_ready  = (state_reg == S_DATA);
  assign blk_valid = (state_reg == S_OUT);
  assign blk_first = blk_valid && first_pending_reg;
  assign blk_last  = blk_valid && final_reg;
  assign blk_data  = blk_reg;

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized self-checking bench for sha256_padder against a byte-queue padding model.
module tb_sha256_padder;
  import sha256_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               in_last;
  logic               blk_valid;
  logic               blk_ready;
  logic [BLOCK_W-1:0] blk_data;
  logic               blk_first;
  logic               blk_last;

  sha256_padder #(.CNT_W(61)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int in_gap_pct  = 0;
  int out_gap_pct = 0;

  logic [7:0]         msg_q[$];
  bit                 last_q[$];
  logic [BLOCK_W-1:0] exp_q[$];
  bit                 expf_q[$];
  bit                 expl_q[$];

  task automatic clear_all();
    msg_q.delete(); last_q.delete();
    exp_q.delete(); expf_q.delete(); expl_q.delete();
  endtask

  // Model: message ++ 0x80 ++ zeros until len%64==56 ++ 64-bit BE bit length.
  task automatic add_msg(input int len, input int kind, input bit terminate);
    logic [7:0] p[$];
    logic [63:0] bits;
    logic [BLOCK_W-1:0] blk;
    int nblk;
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = (kind == 1) ? 8'h61 : 8'($urandom_range(255));
      msg_q.push_back(b);
      last_q.push_back(terminate && (i == len - 1));
      p.push_back(b);
    end
    if (!terminate) return;
    bits = 64'(len) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 64; i++) blk[511 - 8*i -: 8] = p[64*b + i];
      exp_q.push_back(blk);
      expf_q.push_back(b == 0);
      expl_q.push_back(b == nblk - 1);
    end
  endtask

  // Message "0" with its block written out literally.
  task automatic add_lit_zero();
    logic [BLOCK_W-1:0] blk;
    blk = '0;
    blk[511:496] = 16'h3080;
    blk[7:0]     = 8'h08;
    msg_q.push_back(8'h30);
    last_q.push_back(1'b1);
    exp_q.push_back(blk);
    expf_q.push_back(1'b1);
    expl_q.push_back(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_msg();
    int idx = 0;
    int budget = 0;
    bit v, rdy;
    while (idx < msg_q.size()) begin
      @(negedge clk);
      if ($urandom_range(99) < in_gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = msg_q[idx];
        in_last  = last_q[idx];
      end
      v = in_valid; rdy = in_ready;
      @(posedge clk);
      if (v && rdy) idx++;
      if (++budget > 20000) begin
        checks++; failures++;
        $display("FAIL send_timeout: sent=%0d required=%0d", idx, msg_q.size());
        break;
      end
    end
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic recv_msg();
    int b = 0;
    int wait_cyc = 0;
    while (b < exp_q.size()) begin
      @(negedge clk);
      blk_ready = ($urandom_range(99) >= out_gap_pct);
      if (blk_valid) begin
        checks++;
        if (blk_data !== exp_q[b]) begin
          failures++;
          $display("FAIL blk_data[%0d]: got=%h required=%h", b, blk_data, exp_q[b]);
        end
        checks++;
        if (blk_first !== expf_q[b] || blk_last !== expl_q[b]) begin
          failures++;
          $display("FAIL blk_flags[%0d]: first/last got=%b%b required=%b%b",
                   b, blk_first, blk_last, expf_q[b], expl_q[b]);
        end
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL in_ready_in_out: got=%b required=0", in_ready);
        end
        if (blk_ready) begin
          $display("block %0d first=%b last=%b data=%h", b, blk_first, blk_last, blk_data[511:448]);
          b++;
          wait_cyc = 0;
        end
      end
      if (++wait_cyc > 2000) begin
        checks++; failures++;
        $display("FAIL recv_timeout: blocks=%0d required=%0d", b, exp_q.size());
        break;
      end
    end
    @(posedge clk);
    #1 blk_ready = 1'b0;
  endtask

  task automatic run_all();
    fork
      send_msg();
      recv_msg();
    join
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0 || blk_first !== 1'b0 ||
        blk_last !== 1'b0 || blk_data !== '0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b first=%b last=%b data_nz=%b required 1 0 0 0 0",
               in_ready, blk_valid, blk_first, blk_last, |blk_data);
    end
    $display("reset checked");
  endtask

  task automatic test_vector_zero();
    clear_all(); in_gap_pct = 0; out_gap_pct = 0;
    add_lit_zero();
    run_all();
  endtask

  task automatic test_boundaries();
    int lens[5] = '{55, 56, 63, 64, 120};
    foreach (lens[i]) begin
      clear_all(); in_gap_pct = 0; out_gap_pct = 0;
      add_msg(lens[i], 1, 1'b1);
      run_all();
    end
  endtask

  task automatic test_stall();
    clear_all(); in_gap_pct = 0; blk_ready = 1'b0;
    add_msg(64, 0, 1'b1);
    send_msg();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hee; in_last = 1'b0;
      checks++;
      if (blk_valid !== 1'b1 || blk_data !== exp_q[0] || blk_first !== 1'b1 || blk_last !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: vld=%b first=%b last=%b data=%h required data=%h 1 1 0",
                 c, blk_valid, blk_first, blk_last, blk_data[511:448], exp_q[0][511:448]);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_in_ready[%0d]: got=%b required=0", c, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_gap_pct = 0;
    recv_msg();
  endtask

  task automatic test_random();
    clear_all(); in_gap_pct = 30; out_gap_pct = 30;
    for (int m = 0; m < 8; m++) add_msg($urandom_range(1, 150), 0, 1'b1);
    run_all();
  endtask

  task automatic test_back_to_back();
    int lens[8] = '{1, 55, 56, 63, 64, 119, 120, 128};
    clear_all(); in_gap_pct = 0; out_gap_pct = 0;
    foreach (lens[i]) add_msg(lens[i], 0, 1'b1);
    run_all();
  endtask

  task automatic test_reset_mid();
    clear_all(); in_gap_pct = 0;
    add_msg(20, 0, 1'b0);
    send_msg();
    do_reset();
    clear_all(); out_gap_pct = 0;
    add_lit_zero();
    run_all();

    clear_all();
    add_msg(64, 0, 1'b1);
    send_msg();
    do_reset();
    checks++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_out: vld=%b rdy=%b required 0 1", blk_valid, in_ready);
    end
    clear_all();
    add_lit_zero();
    run_all();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; blk_ready = 1'b0;
    test_reset();
    test_vector_zero();
    test_boundaries();
    test_stall();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
